// File: rtl/fpu_pkg.sv
// Shared FPU definitions: arbiter state encoding and default sizing constants.
`ifndef FP16_FRACW
`define FP16_FRACW 10
`endif

package fpu_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_CLEAR,
    ARB_START,
    ARB_BUSY,
    ARB_RESP
  } fmadArbState_t;

  localparam int FMAD_ARB_NREQ    = 4;
  localparam int FMAD_ARB_TIMEOUT = 64;

endpackage

// File: rtl/fmad_arbiter_rr_pick.sv
// rrPick: combinational round-robin pick, first valid requester at or after rrPtr.
module rrPick
  import fpu_pkg::*;
#(
  parameter int NREQ = FMAD_ARB_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] reqValid,
  input  logic [IDW-1:0]  rrPtr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grantIdx,
  output logic            anyValid
);

  always_comb begin : pick
    int j;
    logic [IDW-1:0] jj;
    j        = 0;
    jj       = '0;
    grant    = '0;
    grantIdx = '0;
    anyValid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rrPtr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IDW'(j);
      if (!anyValid && reqValid[jj]) begin
        anyValid  = 1'b1;
        grant[jj] = 1'b1;
        grantIdx  = jj;
      end
    end
  end

endmodule

// File: rtl/fmad_arbiter.sv
// fmad_arbiter: round-robin sharing of one fmad unit among NREQ requesters.
// Busy-state watchdog is built only when FMAD_ARBITER_WATCHDOG_EN is defined.
`ifndef FP16_FRACW
`define FP16_FRACW 10
`endif

module fmad_arbiter
  import fpu_pkg::*;
#(
  parameter int WIDTH    = `FP16_FRACW + 1,
  parameter int OUTWIDTH = 2 * WIDTH,
  parameter int NREQ     = FMAD_ARB_NREQ,
  parameter int IDW      = $clog2(NREQ),
  parameter int TIMEOUT  = FMAD_ARB_TIMEOUT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NREQ-1:0]             reqValid,
  output logic [NREQ-1:0]             reqReady,
  input  logic [NREQ-1:0][WIDTH-1:0]  reqMulIn1,
  input  logic [NREQ-1:0][WIDTH-1:0]  reqMulIn2,
  input  logic [NREQ-1:0][WIDTH-1:0]  reqAddIn,
  input  logic [NREQ-1:0]             reqSub,
  output logic                        rspValid,
  input  logic                        rspReady,
  output logic [IDW-1:0]              rspId,
  output logic [OUTWIDTH-1:0]         rspData,
  output logic                        rspErr,
  output logic [WIDTH-1:0]            fmadMulIn1,
  output logic [WIDTH-1:0]            fmadMulIn2,
  output logic [WIDTH-1:0]            fmadAddIn,
  output logic                        fmadSub,
  output logic                        fmadStart,
  output logic                        fmadReset,
  input  logic [OUTWIDTH-1:0]         fmadOut,
  input  logic                        fmadDone
);

  fmadArbState_t       state_q, state_d;
  logic [IDW-1:0]      rrPtr_q, rrPtr_d;
  logic [IDW-1:0]      rspId_q, rspId_d;
  logic [WIDTH-1:0]    mul1_q, mul1_d, mul2_q, mul2_d, add_q, add_d;
  logic                sub_q, sub_d;
  logic [OUTWIDTH-1:0] rspData_q, rspData_d;
  logic [NREQ-1:0]     gOneHot;
  logic [IDW-1:0]      gIdx;
  logic                anyValid;

  rrPick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .reqValid (reqValid),
    .rrPtr    (rrPtr_q),
    .grant    (gOneHot),
    .grantIdx (gIdx),
    .anyValid (anyValid)
  );

`ifdef FMAD_ARBITER_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wdCnt_q, wdCnt_d;
  logic          rspErr_q, rspErr_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    rspId_d   = rspId_q;
    mul1_d    = mul1_q;
    mul2_d    = mul2_q;
    add_d     = add_q;
    sub_d     = sub_q;
    rspData_d = rspData_q;
`ifdef FMAD_ARBITER_WATCHDOG_EN
    wdCnt_d   = wdCnt_q;
    rspErr_d  = rspErr_q;
`endif
    case (state_q)
      ARB_IDLE: if (anyValid) begin
        mul1_d  = reqMulIn1[gIdx];
        mul2_d  = reqMulIn2[gIdx];
        add_d   = reqAddIn[gIdx];
        sub_d   = reqSub[gIdx];
        rspId_d = gIdx;
        rrPtr_d = (gIdx == IDW'(NREQ - 1)) ? '0 : gIdx + 1'b1;
        state_d = ARB_CLEAR;
      end
      ARB_CLEAR: state_d = ARB_START;
      ARB_START: begin
        state_d = ARB_BUSY;
`ifdef FMAD_ARBITER_WATCHDOG_EN
        wdCnt_d = '0;
`endif
      end
      ARB_BUSY: begin
`ifdef FMAD_ARBITER_WATCHDOG_EN
        wdCnt_d = wdCnt_q + 1'b1;
`endif
        if (fmadDone) begin
          rspData_d = fmadOut;
`ifdef FMAD_ARBITER_WATCHDOG_EN
          rspErr_d  = 1'b0;
`endif
          state_d   = ARB_RESP;
        end
`ifdef FMAD_ARBITER_WATCHDOG_EN
        // a done in the same cycle as the timeout wins above
        else if (wdCnt_d == CW'(TIMEOUT)) begin
          rspData_d = '0;
          rspErr_d  = 1'b1;
          state_d   = ARB_RESP;
        end
`endif
      end
      ARB_RESP: if (rspReady) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ARB_IDLE;
      rrPtr_q   <= '0;
      rspId_q   <= '0;
      mul1_q    <= '0;
      mul2_q    <= '0;
      add_q     <= '0;
      sub_q     <= 1'b0;
      rspData_q <= '0;
`ifdef FMAD_ARBITER_WATCHDOG_EN
      wdCnt_q   <= '0;
      rspErr_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      rspId_q   <= rspId_d;
      mul1_q    <= mul1_d;
      mul2_q    <= mul2_d;
      add_q     <= add_d;
      sub_q     <= sub_d;
      rspData_q <= rspData_d;
`ifdef FMAD_ARBITER_WATCHDOG_EN
      wdCnt_q   <= wdCnt_d;
      rspErr_q  <= rspErr_d;
`endif
    end
  end

  // Grant is gated by reset so no handshake completes while the block is being cleared.
  assign reqReady   = gOneHot & {NREQ{(state_q == ARB_IDLE) && reset}};
  assign rspValid   = (state_q == ARB_RESP);
  assign rspId      = rspId_q;
  assign rspData    = rspData_q;
`ifdef FMAD_ARBITER_WATCHDOG_EN
  assign rspErr     = rspErr_q;
`else
  assign rspErr     = 1'b0;
`endif
  assign fmadMulIn1 = mul1_q;
  assign fmadMulIn2 = mul2_q;
  assign fmadAddIn  = add_q;
  assign fmadSub    = sub_q;
  assign fmadStart  = (state_q == ARB_START);
  assign fmadReset  = (state_q == ARB_CLEAR) || !reset;

endmodule
